// File: rtl/evt_counter_mc.sv
// Multi-channel modulo event counter with per-channel load, direction,
// terminal-count pulse and sticky saturation-overflow flag.
module evt_counter_mc #(
    parameter int NUM_CH    = 4,
    parameter int MAX_COUNT = 255
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [NUM_CH-1:0]        evt_in,
    input  logic [NUM_CH-1:0]        dir_in,
    input  logic [NUM_CH-1:0]        load_in,
    input  logic [$clog2(MAX_COUNT)-1:0] load_val_in,
    input  logic                     sat_in,
    input  logic [NUM_CH-1:0]        clr_ovf_in,
    output logic [NUM_CH*$clog2(MAX_COUNT)-1:0] count_out,
    output logic [NUM_CH-1:0]        tc_out,
    output logic [NUM_CH-1:0]        ovf_out
);
    localparam int CW = $clog2(MAX_COUNT);
    localparam logic [CW-1:0] TOP = CW'(MAX_COUNT - 1);

    // Out-of-range load values pin to the top of the count range.
    logic [CW-1:0] load_clamped;
    always_comb begin
        load_clamped = load_val_in;
        if (32'(load_val_in) >= MAX_COUNT) begin
            load_clamped = TOP;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CW-1:0] count_reg, count_next;
            logic          tc_reg, tc_next;
            logic          ovf_reg, ovf_next;

            always_comb begin
                count_next = count_reg;
                tc_next    = 1'b0;
                ovf_next   = ovf_reg & ~clr_ovf_in[gi];
                if (load_in[gi]) begin
                    count_next = load_clamped;
                end else if (evt_in[gi]) begin
                    if (!dir_in[gi]) begin
                        if (count_reg == TOP) begin
                            tc_next = 1'b1;
                            if (sat_in) ovf_next = 1'b1;
                            else        count_next = '0;
                        end else begin
                            count_next = count_reg + CW'(1);
                        end
                    end else begin
                        if (count_reg == '0) begin
                            tc_next = 1'b1;
                            if (sat_in) ovf_next = 1'b1;
                            else        count_next = TOP;
                        end else begin
                            count_next = count_reg - CW'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk_in) begin
                if (!rst_n_in) begin
                    count_reg <= '0;
                    tc_reg    <= 1'b0;
                    ovf_reg   <= 1'b0;
                end else begin
                    count_reg <= count_next;
                    tc_reg    <= tc_next;
                    ovf_reg   <= ovf_next;
                end
            end

            assign count_out[gi*CW +: CW] = count_reg;
            assign tc_out[gi]             = tc_reg;
            assign ovf_out[gi]            = ovf_reg;
        end
    endgenerate
endmodule

// File: tb/tb_evt_counter_mc.sv
// Directed scoreboard bench for evt_counter_mc with two channels, modulus 10.
module tb_evt_counter_mc;
    localparam int NUM_CH    = 2;
    localparam int MAX_COUNT = 10;
    localparam int CW        = 4;

    logic                   clk_in = 1'b0;
    logic                   rst_n_in;
    logic [NUM_CH-1:0]      evt_in, dir_in, load_in, clr_ovf_in;
    logic [CW-1:0]          load_val_in;
    logic                   sat_in;
    logic [NUM_CH*CW-1:0]   count_out;
    logic [NUM_CH-1:0]      tc_out, ovf_out;

    evt_counter_mc #(.NUM_CH(NUM_CH), .MAX_COUNT(MAX_COUNT)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .evt_in      (evt_in),
        .dir_in      (dir_in),
        .load_in     (load_in),
        .load_val_in (load_val_in),
        .sat_in      (sat_in),
        .clr_ovf_in  (clr_ovf_in),
        .count_out   (count_out),
        .tc_out      (tc_out),
        .ovf_out     (ovf_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [NUM_CH*CW-1:0] count;
        logic [NUM_CH-1:0]    tc;
        logic [NUM_CH-1:0]    ovf;
        string                name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Inputs change on the falling edge; the expectation is for the next rising edge.
    task automatic drv(input logic r, input logic [1:0] evt, input logic [1:0] dir,
                       input logic [1:0] ld, input logic [3:0] lv, input logic sat,
                       input logic [1:0] clr, input logic [3:0] c1, input logic [3:0] c0,
                       input logic [1:0] tc, input logic [1:0] ovf, input string name);
        exp_t e;
        @(negedge clk_in);
        rst_n_in    = r;
        evt_in      = evt;
        dir_in      = dir;
        load_in     = ld;
        load_val_in = lv;
        sat_in      = sat;
        clr_ovf_in  = clr;
        e.count = {c1, c0};
        e.tc    = tc;
        e.ovf   = ovf;
        e.name  = name;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (count_out !== e.count || tc_out !== e.tc || ovf_out !== e.ovf) begin
                    bad++;
                    $display("FAIL %s: got count=%h tc=%b ovf=%b want count=%h tc=%b ovf=%b",
                             e.name, count_out, tc_out, ovf_out, e.count, e.tc, e.ovf);
                end else begin
                    $display("txn %s: count=%h tc=%b ovf=%b ok", e.name, count_out, tc_out, ovf_out);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n_in = 1'b0; evt_in = '0; dir_in = '0; load_in = '0;
        load_val_in = '0; sat_in = 1'b0; clr_ovf_in = '0;

        drv(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, "reset_a");
        drv(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, "reset_b");
        for (int k = 1; k <= 12; k++) begin
            drv(1, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 0, 4'(k % 10),
                (k == 10) ? 2'b01 : 2'b00, 2'b00, "up_wrap");
        end
        drv(1, 2'b00, 2'b00, 2'b01, 0,  0, 2'b00, 0, 0, 2'b00, 2'b00, "load0");
        drv(1, 2'b01, 2'b01, 2'b00, 0,  0, 2'b00, 0, 9, 2'b01, 2'b00, "down_wrap");
        for (int k = 0; k < 3; k++) begin
            drv(1, 2'b01, 2'b00, 2'b00, 0, 1, 2'b00, 0, 9, 2'b01, 2'b01, "sat_up");
        end
        drv(1, 2'b00, 2'b00, 2'b00, 0,  1, 2'b01, 0, 9, 2'b00, 2'b00, "clr_ovf");
        drv(1, 2'b10, 2'b00, 2'b10, 13, 0, 2'b00, 9, 9, 2'b00, 2'b00, "load_clamp13");
        drv(1, 2'b10, 2'b00, 2'b00, 0,  0, 2'b00, 0, 9, 2'b10, 2'b00, "wrap_ch1");
        drv(1, 2'b01, 2'b00, 2'b00, 0,  1, 2'b01, 0, 9, 2'b01, 2'b01, "set_vs_clr");
        drv(1, 2'b10, 2'b10, 2'b00, 0,  1, 2'b00, 0, 9, 2'b10, 2'b11, "sat_down");
        drv(1, 2'b01, 2'b01, 2'b00, 0,  1, 2'b00, 0, 8, 2'b00, 2'b11, "dec");
        drv(1, 2'b01, 2'b00, 2'b01, 10, 0, 2'b00, 0, 9, 2'b00, 2'b11, "load_clamp10");
        drv(1, 2'b11, 2'b00, 2'b00, 0,  0, 2'b00, 1, 0, 2'b01, 2'b11, "both_up");
        drv(1, 2'b00, 2'b00, 2'b01, 5,  0, 2'b10, 1, 5, 2'b00, 2'b01, "load5_clr1");
        drv(1, 2'b01, 2'b00, 2'b00, 0,  0, 2'b00, 1, 6, 2'b00, 2'b01, "pre_rst");
        drv(0, 2'b11, 2'b00, 2'b11, 3,  1, 2'b11, 0, 0, 2'b00, 2'b00, "rst_mid");
        drv(1, 2'b01, 2'b00, 2'b00, 0,  0, 2'b00, 0, 1, 2'b00, 2'b00, "post_rst");
        drv(1, 2'b00, 2'b00, 2'b00, 0,  0, 2'b00, 0, 1, 2'b00, 2'b00, "idle");

        repeat (3) @(posedge clk_in);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
